mod4_mode_sequencer: RTL and testbench

//   Command-side driver for the modulo-4 block: accepts queued mode commands over a

---
 rtl/mod4_mode_sequencer_if.sv | 12 +
 rtl/mod4_mode_sequencer.sv | 98 +++++++++
 tb/tb_mod4_mode_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mod4_mode_sequencer_if.sv
// Command handshake between a mode-command initiator and mod4_mode_sequencer.
interface mod4_mode_sequencer_if #(
  parameter int HOLD_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (output cmd_valid, cmd_mode, cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, cmd_mode, cmd_hold, output cmd_ready);
endinterface

// File: rtl/mod4_mode_sequencer.sv
// Queues mode commands and plays each onto the D1/D2 pair for its hold count.
// state | meaning
// IDLE  | no active command, IDLE_MODE driven, pops as soon as the FIFO holds one
// HOLD  | active mode held on D1/D2, cnt counts remaining cycles down to 1
module mod4_mode_sequencer #(
  parameter int         DEPTH     = 4,
  parameter int         HOLD_W    = 4,
  parameter logic [1:0] IDLE_MODE = 2'b00
) (
  input  logic                      CLK1,
  input  logic                      RST,
  mod4_mode_sequencer_if.slave      cmd,
  output logic                      D1,
  output logic                      D2,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [1:0]        mem_mode [DEPTH];
  logic [HOLD_W-1:0] mem_hold [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  logic [1:0]        mode_nxt;
  logic              busy_nxt, done_nxt;
  logic              push, pop, last;

  // ready depends only on registered level, never on cmd_valid
  assign cmd.cmd_ready = (level != LW'(DEPTH));
  assign push = cmd.cmd_valid & cmd.cmd_ready;
  assign last = (state == HOLD) && (cnt == HOLD_W'(1));
  assign pop  = (level != '0) && ((state == IDLE) || last);

  always_ff @(posedge CLK1 or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge CLK1) begin
    if (push) begin
      mem_mode[wr_ptr] <= cmd.cmd_mode;
      mem_hold[wr_ptr] <= cmd.cmd_hold;
    end
  end

  always_ff @(posedge CLK1 or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      {D1, D2} <= IDLE_MODE;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      {D1, D2} <= mode_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pop)       state_nxt = HOLD;
    else if (last) state_nxt = IDLE;
  end

  // outputs are computed one cycle ahead and registered, so D1/D2 never glitch
  always_comb begin
    cnt_nxt  = cnt;
    mode_nxt = {D1, D2};
    if (pop) begin
      cnt_nxt  = (mem_hold[rd_ptr] == '0) ? HOLD_W'(1) : mem_hold[rd_ptr];
      mode_nxt = mem_mode[rd_ptr];
    end else if (last) begin
      cnt_nxt  = '0;
      mode_nxt = IDLE_MODE;
    end else if (state == HOLD) begin
      cnt_nxt  = cnt - HOLD_W'(1);
    end
    busy_nxt = (state_nxt == HOLD);
    done_nxt = (state_nxt == HOLD) && (cnt_nxt == HOLD_W'(1));
  end

endmodule

// File: tb/tb_mod4_mode_sequencer.sv
// Random and directed command streams checked against a queue-based timing model.
module tb_mod4_mode_sequencer;

  localparam int DEPTH = 4;

  logic       CLK1 = 1'b0;
  logic       RST  = 1'b0;
  logic       D1, D2, busy, done;
  logic [2:0] level;

  mod4_mode_sequencer_if #(.HOLD_W(4)) cmd_if ();

  mod4_mode_sequencer #(.DEPTH(DEPTH), .HOLD_W(4), .IDLE_MODE(2'b00)) dut (
    .CLK1  (CLK1),
    .RST   (RST),
    .cmd   (cmd_if.slave),
    .D1    (D1),
    .D2    (D2),
    .busy  (busy),
    .done  (done),
    .level (level)
  );

  always #5 CLK1 = ~CLK1;

  typedef struct {
    logic [1:0] mode;
    int         hold;
  } cmd_t;

  cmd_t       q[$];
  int         act_left = 0;
  logic [1:0] act_mode = 2'b00;
  bit         last_acc = 1'b0;
  int         checks   = 0;
  int         failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    act_left = 0;
    act_mode = 2'b00;
  endtask

  task automatic check_outputs();
    check_eq("d1d2",  {30'd0, D1, D2}, (act_left > 0) ? {30'd0, act_mode} : 32'd0);
    check_eq("busy",  {31'd0, busy},   (act_left > 0) ? 32'd1 : 32'd0);
    check_eq("done",  {31'd0, done},   (act_left == 1) ? 32'd1 : 32'd0);
    check_eq("level", {29'd0, level},  q.size());
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare just after.
  task automatic step(input bit v, input logic [1:0] m, input int h);
    int hold_v;
    bit acc;
    cmd_t c;
    hold_v = h;
    @(negedge CLK1);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_mode  = m;
    cmd_if.cmd_hold  = hold_v[3:0];
    check_eq("cmd_ready", {31'd0, cmd_if.cmd_ready}, (q.size() != DEPTH) ? 32'd1 : 32'd0);
    acc = v && (q.size() != DEPTH) && RST;
    @(posedge CLK1);
    if (RST) begin
      if (act_left <= 1 && q.size() > 0) begin
        c        = q.pop_front();
        act_mode = c.mode;
        act_left = (c.hold == 0) ? 1 : c.hold;
      end else if (act_left > 0) begin
        act_left--;
      end
      if (acc) q.push_back('{m, hold_v});
    end else begin
      acc = 1'b0;
      model_reset();
    end
    last_acc = acc;
    #1;
    check_outputs();
  endtask

  task automatic push_until(input logic [1:0] m, input int h);
    int n;
    n = 0;
    do begin
      step(1'b1, m, h);
      n++;
    end while (!last_acc && n < 100);
    check_eq("push_accept", {31'd0, last_acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 0);
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mode  = 2'b00;
    cmd_if.cmd_hold  = 4'd0;

    // reset held for three cycles
    RST = 1'b0;
    idle(3);
    RST = 1'b1;
    idle(2);

    // single command, hold 2
    push_until(2'b01, 2);
    idle(5);

    // four back-to-back commands, hold 2 each
    for (int i = 0; i < 4; i++) push_until(2'(i), 2);
    idle(12);

    // hold 0 acts as 1
    push_until(2'b11, 0);
    idle(4);

    // overfill with long holds: the stalled push waits for a pop
    for (int i = 0; i < 6; i++) push_until(2'(i), 15);
    idle(100);

    // steady push-while-pop at level DEPTH-1
    push_until(2'b10, 4);
    for (int i = 0; i < 3; i++) push_until(2'(i), 1);
    for (int i = 0; i < 10; i++) push_until(2'(i + 1), 1);
    idle(20);

    // async reset in the middle of a hold
    push_until(2'b11, 10);
    idle(3);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    check_eq("rst_async_d", {30'd0, D1, D2}, 32'd0);
    check_eq("rst_async_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_async_done", {31'd0, done}, 32'd0);
    check_eq("rst_async_level", {29'd0, level}, 32'd0);
    check_eq("rst_async_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    idle(2);
    RST = 1'b1;
    idle(2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int h;
      h = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      step(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), h);
    end
    idle(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
